// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the data-side load/store path:
//   - LDST_* access-size codes (RISC-V funct3 encoding)
//   - lsu_state_t, the load/store unit handshake state
//   - ldst_ok(), legality + natural-alignment check for one access
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lsu_state_t;

    // True when the size code is legal and the address is naturally aligned
    // for it. Codes 3, 6 and 7 are never legal.
    function automatic logic ldst_ok(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            LDST_B, LDST_BU: ok = 1'b1;
            LDST_H, LDST_HU: ok = ~addr_lo[0];
            LDST_W:          ok = (addr_lo == 2'b00);
            default:         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_rd_extend.sv
// ---------------------------------------------------------------------------
// lsu_rd_extend
// Picks the addressed byte/halfword out of a memory read word and sign- or
// zero-extends it to 32 bits. Purely combinational.
//   size     in   3  access size (LDST_*)
//   addr_lo  in   2  low byte-address bits, select the lane
//   mem_rd   in  32  raw memory read word
//   core_rd  out 32  extended load data (0 for illegal sizes)
// ---------------------------------------------------------------------------
module lsu_rd_extend
    import riscv_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_rd,
    output logic [31:0] core_rd
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = mem_rd[7:0];
            2'd1:    byte_lane = mem_rd[15:8];
            2'd2:    byte_lane = mem_rd[23:16];
            default: byte_lane = mem_rd[31:24];
        endcase
        half_lane = addr_lo[1] ? mem_rd[31:16] : mem_rd[15:0];
    end

    always_comb begin
        case (size)
            LDST_B:  core_rd = {{24{byte_lane[7]}}, byte_lane};
            LDST_BU: core_rd = {24'd0, byte_lane};
            LDST_H:  core_rd = {{16{half_lane[15]}}, half_lane};
            LDST_HU: core_rd = {16'd0, half_lane};
            LDST_W:  core_rd = mem_rd;
            default: core_rd = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Bridges the core's data port to a word-addressed, byte-enabled memory with
// a ready handshake. Stalls the core while an access is outstanding, extends
// load data, and raises one-cycle fault pulses for misaligned/illegal
// accesses (misalign_o) and for memory timeouts (bus_err_o).
//   clk_i, rst_i          clock, asynchronous active-high reset
//   core_req_i/we/size/addr/wd   core request (held stable while stalled)
//   core_rd_o             extended load data, non-zero only on load completion
//   core_stall_o          freezes the core's PC while the access is pending
//   mem_req_o/we/be/addr/wd      memory request side
//   mem_rd_i, mem_ready_i memory read word and completion handshake
//   misalign_o, bus_err_o fault pulses
// Parameter TIMEOUT_CYCLES: BUSY cycles before abort; 0 disables the timeout.
// ---------------------------------------------------------------------------
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [4:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? 5'd0 : 5'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ok;
    logic        timeout_hit;
    logic        load_done;
    logic [31:0] ext_rd;

    assign ok          = core_req_i & ldst_ok(core_size_i, core_addr_i[1:0]);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would create races.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and handshake outputs. The whole body is skipped while
    // rst_i is high so that every output reads 0 during reset, including the
    // instant reset is asserted in the middle of a BUSY access.
    // NOTE: every signal written below gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        core_stall_o = 1'b0;
        mem_req_o    = 1'b0;
        misalign_o   = 1'b0;
        bus_err_o    = 1'b0;
        load_done    = 1'b0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    // mem_ready_i is deliberately ignored here.
                    if (ok) begin
                        core_stall_o = 1'b1;
                        mem_req_o    = 1'b1;
                        state_d      = BUSY;
                        cnt_d        = 5'd0;
                    end else if (core_req_i) begin
                        misalign_o   = 1'b1;
                    end
                end
                BUSY: begin
                    mem_req_o = core_req_i;
                    if (!core_req_i) begin
                        // Core withdrew the request (trap/abort): drop quietly.
                        state_d = IDLE;
                    end else if (mem_ready_i) begin
                        // Ready takes priority over a simultaneous timeout.
                        load_done = ~core_we_i;
                        state_d   = IDLE;
                    end else if (timeout_hit) begin
                        bus_err_o = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        core_stall_o = 1'b1;
                        cnt_d        = cnt_q + 5'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Store lane steering: byte enables select the written lanes, data is
    // replicated across lanes so the memory never needs to shift it.
    always_comb begin
        mem_be_o = 4'b0000;
        mem_wd_o = 32'd0;
        if (!rst_i) begin
            case (core_size_i)
                LDST_B, LDST_BU: begin
                    mem_be_o = 4'b0001 << core_addr_i[1:0];
                    mem_wd_o = {4{core_wd_i[7:0]}};
                end
                LDST_H, LDST_HU: begin
                    mem_be_o = core_addr_i[1] ? 4'b1100 : 4'b0011;
                    mem_wd_o = {2{core_wd_i[15:0]}};
                end
                LDST_W: begin
                    mem_be_o = 4'b1111;
                    mem_wd_o = core_wd_i;
                end
                default: begin
                    mem_be_o = 4'b0000;
                    mem_wd_o = core_wd_i;
                end
            endcase
            if (!core_we_i) begin
                mem_be_o = 4'b0000;
            end
        end
    end

    assign mem_we_o   = core_we_i & mem_req_o;
    assign mem_addr_o = rst_i ? 32'd0 : core_addr_i;

    lsu_rd_extend u_rd_extend (
        .size    (core_size_i),
        .addr_lo (core_addr_i[1:0]),
        .mem_rd  (mem_rd_i),
        .core_rd (ext_rd)
    );

    assign core_rd_o = load_done ? ext_rd : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit. Two instances share the stimulus:
// dut (TIMEOUT_CYCLES=4) is checked everywhere, dut_nt (TIMEOUT_CYCLES=0)
// only in the no-timeout scenario. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
module tb_load_store_unit;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i, core_we_i, mem_ready_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i, core_wd_i, mem_rd_i;

    logic [31:0] rd_a, addr_a, wd_a, rd_b, addr_b, wd_b;
    logic [3:0]  be_a, be_b;
    logic        stall_a, req_a, we_a, mis_a, err_a;
    logic        stall_b, req_b, we_b, mis_b, err_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
        .core_rd_o(rd_a), .core_stall_o(stall_a),
        .mem_req_o(req_a), .mem_we_o(we_a), .mem_be_o(be_a),
        .mem_addr_o(addr_a), .mem_wd_o(wd_a),
        .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i),
        .misalign_o(mis_a), .bus_err_o(err_a)
    );

    load_store_unit #(.TIMEOUT_CYCLES(0)) dut_nt (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
        .core_rd_o(rd_b), .core_stall_o(stall_b),
        .mem_req_o(req_b), .mem_we_o(we_b), .mem_be_o(be_b),
        .mem_addr_o(addr_b), .mem_wd_o(wd_b),
        .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i),
        .misalign_o(mis_b), .bus_err_o(err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input logic rdy);
        core_req_i  = req;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_rd_i    = rd;
        mem_ready_i = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic idle_cycle();
        next_cycle();
        drive(1'b0, 1'b0, LDST_W, 32'd0, 32'd0, 32'd0, 1'b0);
        sample();
    endtask

    initial begin
        // ---- reset: outputs forced to 0 even with a valid request present
        rst_i = 1'b1;
        drive(1'b1, 1'b1, LDST_W, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0);
        #2;
        check("rst_stall", 32'(stall_a), 0);
        check("rst_req",   32'(req_a),   0);
        check("rst_we",    32'(we_a),    0);
        check("rst_be",    32'(be_a),    0);
        check("rst_addr",  addr_a,       0);
        check("rst_wd",    wd_a,         0);
        check("rst_rd",    rd_a,         0);
        drive(1'b0, 1'b0, LDST_W, 32'd0, 32'd0, 32'd0, 1'b0);
        #1 rst_i = 1'b0;

        // ---- SW 0xDEADBEEF @0x100, ready on 2nd BUSY cycle
        next_cycle();
        drive(1'b1, 1'b1, LDST_W, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0);
        sample();
        check("sw_c0_stall", 32'(stall_a), 1);
        check("sw_c0_req",   32'(req_a),   1);
        check("sw_c0_we",    32'(we_a),    1);
        check("sw_c0_be",    32'(be_a),    32'hF);
        check("sw_c0_wd",    wd_a,         32'hDEAD_BEEF);
        check("sw_c0_addr",  addr_a,       32'h0000_0100);
        next_cycle();
        sample();
        check("sw_c1_stall", 32'(stall_a), 1);
        check("sw_c1_err",   32'(err_a),   0);
        next_cycle();
        mem_ready_i = 1'b1;
        sample();
        check("sw_c2_stall", 32'(stall_a), 0);
        check("sw_c2_err",   32'(err_a),   0);
        check("sw_c2_we",    32'(we_a),    1);
        check("sw_c2_rd",    rd_a,         0);
        idle_cycle();
        check("sw_idle_stall", 32'(stall_a), 0);
        check("sw_idle_req",   32'(req_a),   0);

        // ---- LB @0x103 then back-to-back LBU, mem word 0x80FF1234
        next_cycle();
        drive(1'b1, 1'b0, LDST_B, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1'b0);
        sample();
        check("lb_c0_be",  32'(be_a), 0);
        check("lb_c0_we",  32'(we_a), 0);
        check("lb_c0_rd",  rd_a,      0);
        next_cycle();
        mem_ready_i = 1'b1;
        sample();
        check("lb_rd",     rd_a, 32'hFFFF_FF80);
        check("lb_stall",  32'(stall_a), 0);
        next_cycle();
        core_size_i = LDST_BU;  // ready still high: must be ignored in IDLE
        sample();
        check("lbu_c0_stall", 32'(stall_a), 1);
        check("lbu_c0_rd",    rd_a, 0);
        next_cycle();
        sample();
        check("lbu_rd",    rd_a, 32'h0000_0080);
        idle_cycle();

        // ---- SH 0xABCD @0x202, then LHU / LH @0x202 with 0xF00D0000
        next_cycle();
        drive(1'b1, 1'b1, LDST_H, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1'b0);
        sample();
        check("sh_be", 32'(be_a), 32'hC);
        check("sh_wd", wd_a,      32'hABCD_ABCD);
        next_cycle();
        mem_ready_i = 1'b1;
        sample();
        check("sh_done_stall", 32'(stall_a), 0);
        idle_cycle();
        next_cycle();
        drive(1'b1, 1'b0, LDST_HU, 32'h0000_0202, 32'h0, 32'hF00D_0000, 1'b0);
        sample();
        check("lhu_be", 32'(be_a), 0);
        next_cycle();
        mem_ready_i = 1'b1;
        sample();
        check("lhu_rd", rd_a, 32'h0000_F00D);
        next_cycle();
        core_size_i = LDST_H;
        sample();
        next_cycle();
        sample();
        check("lh_rd", rd_a, 32'hFFFF_F00D);
        idle_cycle();

        // ---- misaligned LW @0x101, then illegal size 3 @0x100
        next_cycle();
        drive(1'b1, 1'b0, LDST_W, 32'h0000_0101, 32'h0, 32'h0, 1'b0);
        sample();
        check("mis_lw",       32'(mis_a),   1);
        check("mis_lw_req",   32'(req_a),   0);
        check("mis_lw_stall", 32'(stall_a), 0);
        next_cycle();
        core_size_i = 3'd3;
        core_addr_i = 32'h0000_0100;
        sample();
        check("ill_sz3",       32'(mis_a),   1);
        check("ill_sz3_req",   32'(req_a),   0);
        check("ill_sz3_stall", 32'(stall_a), 0);
        idle_cycle();
        check("mis_clear", 32'(mis_a), 0);

        // ---- timeout (TIMEOUT_CYCLES=4): LW with no ready
        next_cycle();
        drive(1'b1, 1'b0, LDST_W, 32'h0000_0040, 32'h0, 32'h1234_5678, 1'b0);
        sample();
        check("to_idle_stall", 32'(stall_a), 1);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            sample();
            check($sformatf("to_busy%0d_stall", i), 32'(stall_a), 1);
            check($sformatf("to_busy%0d_err", i),   32'(err_a),   0);
        end
        next_cycle();
        sample();
        check("to_err",   32'(err_a),   1);
        check("to_stall", 32'(stall_a), 0);
        check("to_rd",    rd_a,         0);
        // Back in IDLE: ready is ignored, so the new access stalls.
        next_cycle();
        mem_ready_i = 1'b1;
        sample();
        check("to_after_stall", 32'(stall_a), 1);
        check("to_after_err",   32'(err_a),   0);
        idle_cycle();
        idle_cycle();

        // ---- TIMEOUT_CYCLES=0: ready only after 20 BUSY cycles
        next_cycle();
        drive(1'b1, 1'b0, LDST_W, 32'h0000_0040, 32'h0, 32'h1234_5678, 1'b0);
        sample();
        check("nt_idle_stall", 32'(stall_b), 1);
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            sample();
            check($sformatf("nt_busy%0d_stall", i), 32'(stall_b), 1);
            check($sformatf("nt_busy%0d_err", i),   32'(err_b),   0);
        end
        next_cycle();
        mem_ready_i = 1'b1;
        sample();
        check("nt_done_stall", 32'(stall_b), 0);
        check("nt_done_err",   32'(err_b),   0);
        check("nt_done_rd",    rd_b,         32'h1234_5678);
        idle_cycle();
        idle_cycle();

        // ---- asynchronous reset in the middle of a BUSY store
        next_cycle();
        drive(1'b1, 1'b1, LDST_W, 32'h0000_0100, 32'h1122_3344, 32'h0, 1'b0);
        sample();
        check("ar_c0_stall", 32'(stall_a), 1);
        next_cycle();
        #2 rst_i = 1'b1;
        #1;
        check("ar_stall", 32'(stall_a), 0);
        check("ar_req",   32'(req_a),   0);
        check("ar_we",    32'(we_a),    0);
        check("ar_be",    32'(be_a),    0);
        check("ar_wd",    wd_a,         0);
        check("ar_addr",  addr_a,       0);
        check("ar_err",   32'(err_a),   0);
        check("ar_mis",   32'(mis_a),   0);
        core_req_i = 1'b0;
        sample();
        rst_i = 1'b0;
        // SB @0x001 with ready already high: from IDLE it must still stall once.
        next_cycle();
        drive(1'b1, 1'b1, LDST_B, 32'h0000_0001, 32'h0000_005A, 32'h0, 1'b1);
        sample();
        check("sb_c0_stall", 32'(stall_a), 1);
        check("sb_c0_req",   32'(req_a),   1);
        check("sb_c0_be",    32'(be_a),    32'h2);
        check("sb_c0_wd",    wd_a,         32'h5A5A_5A5A);
        next_cycle();
        sample();
        check("sb_done_stall", 32'(stall_a), 0);
        check("sb_done_err",   32'(err_a),   0);
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side responder for the core's data interface (core_req/we/size/addr/wd in, rd/stall out).
- Converts core accesses into word-addressed, byte-enabled requests to the data memory and waits for a ready handshake.
- Sign/zero-extends load data and generates the stall that freezes the core's PC until the access completes.
- Sits between processor_core and the data memory in the top-level processor system.

Parameters:
- TIMEOUT_CYCLES, 16: maximum BUSY cycles before the access is aborted with bus_err_o. 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- core_req_i  in  1  core requests a data access
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  access size, RISC-V funct3 encoding (LDST_*)
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, right-aligned
- core_rd_o  out  32  extended load data; valid in the completion cycle
- core_stall_o  out  1  freezes the core while an access is pending
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  memory address, equal to core_addr_i
- mem_wd_o  out  32  lane-replicated store data
- mem_rd_i  in  32  memory read word
- mem_ready_i  in  1  memory has completed the current request
- misalign_o  out  1  fault pulse: misaligned access or illegal size
- bus_err_o  out  1  fault pulse: timeout

Behaviour:
- FSM states: IDLE, BUSY. 5-bit timeout counter cnt.
- While rst_i is high: state=IDLE, cnt=0, and every output is 0.
- Sizes: LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5. Encodings 3, 6 and 7 are illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00.
- ok = core_req_i & legal size & aligned.
- IDLE:
  - If core_req_i & !ok: misalign_o=1 for that cycle, core_stall_o=0, mem_req_o=0, state stays IDLE.
  - If ok: core_stall_o=1, mem_req_o=1, next state BUSY, cnt=0.
  - mem_ready_i is ignored in IDLE.
- BUSY:
  - mem_req_o=core_req_i. The core holds its inputs stable while stalled.
  - If mem_ready_i: core_stall_o=0, core_rd_o=extended mem_rd_i (loads; 0 for stores), next state IDLE.
  - Else if TIMEOUT_CYCLES!=0 and cnt==TIMEOUT_CYCLES-1: bus_err_o=1, core_stall_o=0, core_rd_o=0, next state IDLE.
  - Else: core_stall_o=1, cnt++.
  - If core_req_i drops (core abort/trap): next state IDLE, no stall, no fault.
- Latency: minimum 1 stall cycle. The core advances on the mem_ready_i cycle. A back-to-back request restarts from IDLE the following cycle.
- mem_be_o:
  - Byte: 1<<addr[1:0].
  - Half: addr[1] ? 1100 : 0011.
  - Word: 1111.
  - Forced to 0000 on loads.
- mem_wd_o:
  - Byte: {4{wd[7:0]}}.
  - Half: {2{wd[15:0]}}.
  - Word: wd.
- mem_we_o = core_we_i & mem_req_o.
- Load extension:
  - Select the byte lane by addr[1:0] and the halfword by addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- core_rd_o is 0 in every cycle that is not a load completion.
- Asserting reset mid-BUSY returns the FSM to IDLE immediately (asynchronously). No completion or fault is reported.
- Ready and timeout in the same cycle: ready wins.

Decomposition:
- Shared package riscv_pkg holds the LDST_* constants and the lsu_state_t enum (IDLE, BUSY).
- One combinational sub-module, lsu_rd_extend (inputs: size, addr[1:0], mem_rd; output: core_rd), is natural.
- The FSM, timeout counter and store-lane logic live in load_store_unit.

Test Plan:
- SW 0xDEADBEEF to addr 0x100; ready on the 2nd BUSY cycle -> mem_be_o=1111 and mem_we_o=1; stall high for 2 cycles, low in the ready cycle; bus_err_o=0.
- LB at 0x103 with mem_rd_i=0x80FF_1234 -> mem_be_o=0000 and core_rd_o=0xFFFFFF80 on ready. The same access as LBU -> 0x00000080.
- SH of core_wd_i=0x0000ABCD at 0x202 -> mem_be_o=1100, mem_wd_o=0xABCDABCD. LHU at 0x202 with mem_rd_i=0xF00D0000 -> core_rd_o=0x0000F00D.
- LW at 0x101, then size 3 at 0x100 -> misalign_o=1 for one cycle each, mem_req_o=0, core_stall_o=0.
- TIMEOUT_CYCLES=4, LW with mem_ready_i never asserted -> stall high for 4 cycles; bus_err_o=1 in the 4th BUSY cycle with stall=0; then IDLE. With TIMEOUT_CYCLES=0 and ready after 20 cycles -> no error.
- rst_i asserted asynchronously mid-BUSY -> all outputs 0 immediately; after release, a new SB at 0x001 completes normally with mem_be_o=0010.
